// File: rtl/vdma_pkg.sv
// vdma_pkg: shared AXI burst constants, packer FSM encoding and clog2 helper.
package vdma_pkg;

    localparam int AXI_MAX_BURST = 256;
    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} burst_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; the head is readable
// combinationally, and the pointers carry an extra wrap bit so count = wr - rd.
module sync_fifo_fwft
    import vdma_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign full = count == (AW + 1)'(DEPTH);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock)
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;

    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (rd_en && !empty) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end

endmodule

// File: rtl/wr_burst_packer.sv
// wr_burst_packer: buffers the combiner's word stream and cuts it into AXI
// write bursts, one address request per burst followed by its beats.
module wr_burst_packer
    import vdma_pkg::*;
#(
    parameter int DSIZE = 256,
    parameter int DEPTH = 64,
    parameter int BURST_LEN = 16
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   in_wr_en,
    input  logic [DSIZE-1:0]       in_data,
    input  logic                   in_last,
    output logic                   burst_req,
    output logic [AXI_LEN_W-1:0]   burst_len,
    input  logic                   burst_ack,
    output logic [DSIZE-1:0]       wdata,
    output logic                   wvalid,
    input  logic                   wready,
    output logic                   wlast,
    output logic [clog2(DEPTH):0]  fifo_count,
    output logic                   overflow
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam int LW = clog2(AXI_MAX_BURST) + 1;

    burst_state_t state, state_n;
    logic [LW-1:0] acc, acc_inc, beats, lq_head, lq_din;
    logic [DSIZE-1:0] df_head;
    logic [CW-1:0] lq_count_unused;
    logic df_empty, lq_empty, df_full_unused, lq_full_unused;
    logic accept, close, lq_push, lq_pop, beat;

    assign accept = in_wr_en && fifo_count < CW'(DEPTH);
    assign acc_inc = acc + LW'(1);
    assign close = acc_inc == LW'(BURST_LEN) || in_last;
    // a dropped line-end word still closes whatever partial burst is pending
    assign lq_push = accept ? close : in_wr_en && in_last && acc != '0;
    assign lq_din = accept ? acc_inc : acc;
    assign lq_pop = state == ST_REQ && burst_ack;
    assign beat = wvalid && wready;
    assign burst_req = state == ST_REQ;
    assign burst_len = burst_req ? lq_head[AXI_LEN_W-1:0] - AXI_LEN_W'(1) : '0;
    assign wvalid = state == ST_DATA && !df_empty;
    assign wlast = state == ST_DATA && beats == LW'(1);
    assign wdata = wvalid ? df_head : '0;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (!lq_empty || lq_push) state_n = ST_REQ;
            ST_REQ:  if (burst_ack) state_n = ST_DATA;
            ST_DATA: if (beat && beats == LW'(1)) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            state <= ST_IDLE;
            acc <= '0;
            beats <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            acc <= lq_push ? '0 : accept ? acc_inc : acc;
            beats <= lq_pop ? lq_head : beat ? beats - LW'(1) : beats;
            overflow <= overflow || (in_wr_en && !accept);
        end

    sync_fifo_fwft #(.WIDTH(DSIZE), .DEPTH(DEPTH)) u_data_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_en   (beat),
        .rd_data (df_head),
        .empty   (df_empty),
        .full    (df_full_unused),
        .count   (fifo_count)
    );

    sync_fifo_fwft #(.WIDTH(LW), .DEPTH(DEPTH)) u_len_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (lq_push),
        .wr_data (lq_din),
        .rd_en   (lq_pop),
        .rd_data (lq_head),
        .empty   (lq_empty),
        .full    (lq_full_unused),
        .count   (lq_count_unused)
    );

endmodule

// File: tb/tb_wr_burst_packer.sv
// tb_wr_burst_packer: directed scoreboard bench for the burst packer.
module tb_wr_burst_packer;

    typedef struct {
        logic [255:0] d;
        logic         l;
    } beat_t;

    logic         clock = 0;
    logic         rst_n = 1;
    logic         in_wr_en = 0;
    logic [255:0] in_data = '0;
    logic         in_last = 0;
    logic         burst_req;
    logic [7:0]   burst_len;
    logic         burst_ack = 0;
    logic [255:0] wdata;
    logic         wvalid;
    logic         wready = 0;
    logic         wlast;
    logic [6:0]   fifo_count;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int m_acc = 0;
    int hold = 1;
    int wait_cnt = 0;
    int phase = 0;
    int beats_seen = 0;
    logic auto_ack = 1;
    logic wr_mode = 0;
    logic wr_level = 1;
    logic chk_nodrop = 0;
    logic in_burst = 0;
    beat_t exp_q[$];
    logic [7:0] len_q[$];
    beat_t e;
    logic [255:0] d;

    wr_burst_packer dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_wr_en   (in_wr_en),
        .in_data    (in_data),
        .in_last    (in_last),
        .burst_req  (burst_req),
        .burst_len  (burst_len),
        .burst_ack  (burst_ack),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .wlast      (wlast),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic put(input logic [255:0] w, input logic last, input logic acc_exp);
        in_wr_en = 1;
        in_data = w;
        in_last = last;
        if (acc_exp) begin
            m_acc++;
            if (m_acc == 16 || last) begin
                exp_q.push_back('{w, 1'b1});
                len_q.push_back(8'(m_acc - 1));
                m_acc = 0;
            end else exp_q.push_back('{w, 1'b0});
        end
        @(posedge clock); #1;
        in_wr_en = 0;
        in_last = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
        chk(tag, n < 3000, 1);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
    endtask

    // ack responder and wready pattern generator, both driven just after the edge
    always @(posedge clock) begin
        #1;
        if (!rst_n || !burst_req) begin
            burst_ack = 0;
            wait_cnt = 0;
        end else if (!burst_ack) begin
            wait_cnt++;
            burst_ack = auto_ack && wait_cnt > hold;
        end
        if (wr_mode) begin
            wready = (phase == 0);
            phase = (phase + 1) % 3;
        end else wready = wr_level;
    end

    always @(negedge clock) if (rst_n) begin
        if (burst_req) chk("wvalid_during_req", wvalid, 0);
        if (burst_req && burst_ack) begin
            chk("req_expected", len_q.size() != 0, 1);
            if (len_q.size() != 0) chk("burst_len", burst_len, len_q.pop_front());
        end
        if (chk_nodrop && in_burst) chk("wvalid_drop", wvalid, 1);
        if (wvalid && wready) begin
            beats_seen++;
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wdata", wdata, e.d);
                chk("wlast", wlast, e.l);
            end
            in_burst = !wlast;
        end
    end

    initial begin
        int n;
        #3 rst_n = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req", burst_req, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_len", burst_len, 0);
        chk("rst_wdata", wdata, 0);
        rst_n = 1;
        @(posedge clock); #1;

        for (int i = 1; i <= 40; i++) put(rnd(), i == 40, 1);
        drain("t1_drain");

        put(rnd(), 1, 1);
        chk("t2_req", burst_req, 1);
        chk("t2_len", burst_len, 0);
        drain("t2_drain");

        wr_mode = 1;
        chk_nodrop = 1;
        for (int i = 1; i <= 16; i++) put(rnd(), 0, 1);
        drain("t3_drain");
        wr_mode = 0;
        chk_nodrop = 0;

        hold = 10;
        for (int i = 1; i <= 4; i++) put(rnd(), i == 4, 1);
        n = 0;
        while (!burst_req && n < 50) begin @(posedge clock); #1; n++; end
        chk("t4_req_seen", burst_req, 1);
        repeat (10) begin
            chk("t4_req_hold", burst_req, 1);
            chk("t4_len_hold", burst_len, 3);
            @(posedge clock); #1;
        end
        drain("t4_drain");
        hold = 1;

        auto_ack = 0;
        wr_level = 0;
        @(posedge clock); #1;
        for (int i = 1; i <= 70; i++) begin
            put(rnd(), 0, i <= 64);
            if (i == 64) begin
                chk("t5_count64", fifo_count, 64);
                chk("t5_no_ovf", overflow, 0);
            end
            if (i == 65) chk("t5_ovf65", overflow, 1);
        end
        chk("t5_count_sat", fifo_count, 64);
        chk("t5_ovf_sticky", overflow, 1);
        auto_ack = 1;
        wr_level = 1;
        drain("t5_drain");
        chk("t5_ovf_after", overflow, 1);

        beats_seen = 0;
        for (int i = 1; i <= 16; i++) put(rnd(), 0, 1);
        n = 0;
        while (beats_seen < 4 && n < 200) begin @(posedge clock); #1; n++; end
        chk("t6_reach_beat5", beats_seen, 4);
        rst_n = 0;
        #1;
        chk("t6_req", burst_req, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_wlast", wlast, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_len", burst_len, 0);
        chk("t6_wdata", wdata, 0);
        exp_q.delete();
        len_q.delete();
        m_acc = 0;
        in_burst = 0;
        @(posedge clock); #1;
        rst_n = 1;
        @(posedge clock); #1;
        for (int i = 1; i <= 3; i++) put(rnd(), i == 3, 1);
        chk("t6_new_req", burst_req, 1);
        chk("t6_new_len", burst_len, 2);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
